seg7_display_arbiter: RTL and testbench
=======================================

// Module: seg7_display_arbiter
// PURPOSE
//   Shares the single 8-digit 7-segment display between NREQ requesters (PC, register
//   probe, debug counters, ...). Round-robin arbitration. Each grant produces a one-cycle
//   chip-select pulse plus a 32-bit word for the display driver's cs/iData inputs. The
//   winner then owns the display for DWELL cycles so the value is readable before the
//   next source may overwrite it.
// PARAMETERS
//   NREQ   4           number of requesters, 2..8
//   SRCW   3           width of the source index, >= clog2(NREQ)
//   DWELL  50_000_000  display ownership per grant in clk cycles, >= 1 (0.5 s @ 100 MHz)
//   CNTW   26          dwell counter width, 2^CNTW > DWELL
// PORTS
//   clk    in   1          system clock, all logic on posedge
//   reset  in   1          synchronous, active-high
//   iReq   in   NREQ       request per source; held until that source's oGnt bit pulses
//   iData  in   NREQ*32    word per source; source i in bits [32*i+31 : 32*i]
//   iHold  in   1          freeze: while high, the dwell counter does not advance
//   oGnt   out  NREQ       one-hot grant pulse, one cycle
//   oCs    out  1          load strobe to the display driver, one cycle, coincides with oGnt
//   oData  out  32         word to the display driver, stable from the grant until the next grant
//   oSrc   out  SRCW       index of the current or last owner
//   oBusy  out  1          high while state is HOLD
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset, sampled on posedge: state=IDLE, ptr=0, cnt=0, oGnt=0, oCs=0, oData=0,
//     oSrc=0, oBusy=0. A reset mid-HOLD aborts the dwell. A request pending at reset is
//     not served until it is seen again after reset is released.
//   - Arbitration: search iReq from ptr upward, wrapping modulo NREQ. The first set bit k
//     wins. On the grant, ptr <= (k+1) mod NREQ, wrapping from NREQ-1 to 0.
//   - Grant edge, taken when state=IDLE, or when state=HOLD with cnt==0 and iHold=0, and
//     |iReq==1:
//     oGnt[k]=1, oCs=1, oData=iData[k], oSrc=k, cnt=DWELL-1, state=HOLD, oBusy=1.
//     oData is iData[k] as sampled on that same edge.
//   - Latency: a request seen on edge N has oGnt/oCs high during cycle N+1.
//   - oGnt and oCs clear on the following edge, unconditionally.
//   - HOLD, when not granting:
//     - iHold=1: cnt holds.
//     - else cnt>0: cnt decrements.
//     - else cnt==0 and no request: state=IDLE, oBusy=0.
//   - Continuous requesters are granted exactly DWELL cycles apart. With iHold=0 there are
//     no idle cycles between owners.
//   - DWELL=1: a grant is possible on every edge. oCs pulses back-to-back.
//   - A requester dropping iReq before its grant is skipped; there is no penalty.
//     Simultaneous requests resolve purely by ptr order.
//   - oData and oSrc keep the last owner's values in IDLE. The display keeps its content.
//   - iHold in IDLE has no effect. The first grant still occurs normally.
// CONFIGURATION
//   SEG7_ARB_TAG_EN defined:
//     oData[31:28] = source index k, zero-extended to 4 bits. oData[27:0] = iData[k][27:0].
//     The left digit then shows which source is displayed.
//   SEG7_ARB_TAG_EN undefined:
//     oData = iData[k], all 32 bits unmodified.
// TESTING  (NREQ=4, DWELL=4)
//   1. reset held 3 cycles with iReq=4'b1111
//      -> all outputs 0 throughout. First grant is to source 0, one cycle after reset falls.
//   2. iReq=4'b0100, iData[2]=32'h12345678 at edge N
//      -> cycle N+1: oGnt=4'b0100, oCs=1, oData=32'h12345678, oSrc=2, oBusy=1.
//      -> oBusy falls after 4 cycles if the request is then dropped.
//   3. iReq=4'b1111 held constantly (grants drop each bit for one cycle, then re-raise)
//      -> grants to 0,1,2,3,0 spaced exactly 4 cycles apart. oCs has 4 pulses in 16 cycles.
//   4. grant to src 1, iHold=1 for 10 cycles starting 1 cycle after grant, iReq[3]=1 pending
//      -> no grant while held. Src 3 is granted exactly 4 cycles after iHold falls.
//   5. reset asserted 2 cycles into HOLD of src 2, then released with iReq=4'b1000
//      -> state IDLE, oData=0. Src 3 is granted one cycle later (ptr=0 search).
//   6. SEG7_ARB_TAG_EN defined, iReq[3]=1, iData[3]=32'hABCDEF01
//      -> oData=32'h3BCDEF01, oSrc=3. Undefined: oData=32'hABCDEF01.

Source files
------------

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter that shares one 8-digit 7-segment display between NREQ sources.
// Optional feature: define SEG7_ARB_TAG_EN to show the winning source index in the top digit.
module seg7_display_arbiter #(
  parameter int NREQ  = 4,
  parameter int SRCW  = 3,
  parameter int DWELL = 50_000_000,
  parameter int CNTW  = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      iReq,
  input  logic [NREQ*32-1:0]   iData,
  input  logic                 iHold,
  output logic [NREQ-1:0]      oGnt,
  output logic                 oCs,
  output logic [31:0]          oData,
  output logic [SRCW-1:0]      oSrc,
  output logic                 oBusy
);

  localparam int SW1 = SRCW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [SRCW-1:0]   ptr;
  logic [CNTW-1:0]   cnt;

  logic              found;
  logic [SRCW-1:0]   win;
  logic [SW1-1:0]    sum;
  logic [31:0]       sel;
  logic [31:0]       word;
  logic [SRCW-1:0]   next_ptr;
  logic [NREQ-1:0]   gnt_vec;
  logic              can_grant;

  // Search from ptr upward with wrap; sum is one bit wider so ptr+i never overflows.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + SW1'(i);
      if (sum >= SW1'(NREQ))
        sum = sum - SW1'(NREQ);
      if (!found && |(iReq & (NREQ'(1) << sum))) begin
        found = 1'b1;
        win   = sum[SRCW-1:0];
      end
    end
  end

  always_comb begin
    sel  = 32'(iData >> (32 * win));
    word = sel;
`ifdef SEG7_ARB_TAG_EN
    word[31:28] = 4'(win);
`else
`endif
    next_ptr  = (win == SRCW'(NREQ - 1)) ? '0 : win + 1'b1;
    gnt_vec   = NREQ'(1) << win;
    can_grant = (state == IDLE) || ((cnt == '0) && !iHold);
  end

  // A new owner may take over once the dwell count has drained, with no idle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      oGnt  <= '0;
      oCs   <= 1'b0;
      oData <= '0;
      oSrc  <= '0;
      oBusy <= 1'b0;
    end else begin
      oGnt <= '0;
      oCs  <= 1'b0;
      if (can_grant && found) begin
        oGnt  <= gnt_vec;
        oCs   <= 1'b1;
        oData <= word;
        oSrc  <= win;
        ptr   <= next_ptr;
        cnt   <= CNTW'(DWELL - 1);
        state <= HOLD;
        oBusy <= 1'b1;
      end else if (state == HOLD && !iHold) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed scoreboard bench for seg7_display_arbiter with NREQ=4, DWELL=4.
// Honours SEG7_ARB_TAG_EN when computing expected display words.
module tb_seg7_display_arbiter;

  localparam int NREQ  = 4;
  localparam int SRCW  = 3;
  localparam int DWELL = 4;
  localparam int CNTW  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     iReq;
  logic [NREQ*32-1:0]  iData;
  logic                iHold;
  logic [NREQ-1:0]     oGnt;
  logic                oCs;
  logic [31:0]         oData;
  logic [SRCW-1:0]     oSrc;
  logic                oBusy;

  logic [31:0] src_data [NREQ];
  assign iData = {src_data[3], src_data[2], src_data[1], src_data[0]};

  typedef struct {
    int          src;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   cs_count = 0;

  seg7_display_arbiter #(.NREQ(NREQ), .SRCW(SRCW), .DWELL(DWELL), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .iReq  (iReq),
    .iData (iData),
    .iHold (iHold),
    .oGnt  (oGnt),
    .oCs   (oCs),
    .oData (oData),
    .oSrc  (oSrc),
    .oBusy (oBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_word(input int k, input logic [31:0] d);
    logic [31:0] w;
    w = d;
`ifdef SEG7_ARB_TAG_EN
    w[31:28] = 4'(k);
`endif
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] req, input logic hold);
    reset = r;
    iReq  = req;
    iHold = hold;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a grant of source k on the posedge 'ahead' edges from now.
  task automatic push_grant(input int k, input int ahead);
    exp_t e;
    e.src  = k;
    e.data = exp_word(k, src_data[k]);
    e.cyc  = cyc + ahead;
    sb.push_back(e);
  endtask

  task automatic check_idle_zero(input string tag);
    checkOutput({tag, "_gnt"},  32'(oGnt),  32'h0);
    checkOutput({tag, "_cs"},   32'(oCs),   32'h0);
    checkOutput({tag, "_data"}, oData,      32'h0);
    checkOutput({tag, "_src"},  32'(oSrc),  32'h0);
    checkOutput({tag, "_busy"}, 32'(oBusy), 32'h0);
  endtask

  // Grant monitor: every strobe must match the oldest scoreboard entry, including its cycle.
  always @(negedge clk) begin
    if (oCs === 1'b1 || |oGnt) begin
      cs_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_grant", 32'(oGnt), 32'h0);
      end else begin
        exp_t e;
        logic [NREQ-1:0] one;
        e   = sb.pop_front();
        one = 4'b0001;
        checkOutput("grant_vec",   32'(oGnt),  32'(one << e.src));
        checkOutput("grant_cs",    32'(oCs),   32'h1);
        checkOutput("grant_data",  oData,      e.data);
        checkOutput("grant_src",   32'(oSrc),  32'(e.src));
        checkOutput("grant_busy",  32'(oBusy), 32'h1);
        checkOutput("grant_cycle", 32'(cyc),   32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    src_data[0] = 32'h0BAD0000;
    src_data[1] = 32'h1CAFE111;
    src_data[2] = 32'h12345678;
    src_data[3] = 32'h3D00D333;

    // Reset held with every source requesting: nothing may leak out.
    applyStimulus(1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_idle_zero("reset_hold");
    end
    applyStimulus(1'b0, 4'b1111, 1'b0);
    push_grant(0, 1);
    tick(1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(3);
    checkOutput("t1_busy_last", 32'(oBusy), 32'h1);
    tick(1);
    checkOutput("t1_busy_fall", 32'(oBusy), 32'h0);
    checkOutput("t1_keep_data", oData, exp_word(0, src_data[0]));
    checkOutput("t1_keep_src",  32'(oSrc), 32'h0);

    // Single request from source 2.
    applyStimulus(1'b0, 4'b0100, 1'b0);
    push_grant(2, 1);
    tick(1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(3);
    checkOutput("t2_busy_held", 32'(oBusy), 32'h1);
    tick(1);
    checkOutput("t2_busy_fall", 32'(oBusy), 32'h0);
    checkOutput("t2_keep_data", oData, exp_word(2, src_data[2]));

    // All sources requesting continuously from ptr=0.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    c0 = cs_count;
    for (int i = 0; i < 5; i++) begin
      int k;
      k = i % NREQ;
      push_grant(k, 1);
      tick(1);
      iReq[k] = 1'b0;
      tick(1);
      iReq[k] = 1'b1;
      tick(2);
      if (i == 3)
        checkOutput("t3_cs_pulses", 32'(cs_count - c0), 32'd4);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(1);
    checkOutput("t3_idle", 32'(oBusy), 32'h0);

    // Freeze the dwell of source 1 while source 3 waits.
    applyStimulus(1'b0, 4'b0010, 1'b0);
    push_grant(1, 1);
    tick(1);
    applyStimulus(1'b0, 4'b1000, 1'b1);
    tick(10);
    checkOutput("t4_busy_frozen", 32'(oBusy), 32'h1);
    checkOutput("t4_src_frozen",  32'(oSrc),  32'h1);
    applyStimulus(1'b0, 4'b1000, 1'b0);
    push_grant(3, 4);
    tick(4);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(4);
    checkOutput("t4_idle", 32'(oBusy), 32'h0);

    // Reset two cycles into a dwell, with source 3 pending across the reset.
    applyStimulus(1'b0, 4'b0100, 1'b0);
    push_grant(2, 1);
    tick(1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(1);
    applyStimulus(1'b1, 4'b1000, 1'b0);
    tick(1);
    check_idle_zero("t5_reset");
    applyStimulus(1'b0, 4'b1000, 1'b0);
    push_grant(3, 1);
    tick(1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(4);
    checkOutput("t5_idle", 32'(oBusy), 32'h0);

    // Tag visibility on source 3; iHold in IDLE must not delay the grant.
    src_data[3] = 32'hABCDEF01;
    applyStimulus(1'b0, 4'b1000, 1'b1);
    push_grant(3, 1);
    tick(1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
`ifdef SEG7_ARB_TAG_EN
    checkOutput("t6_tag_data", oData, 32'h3BCDEF01);
`else
    checkOutput("t6_tag_data", oData, 32'hABCDEF01);
`endif
    tick(4);
    checkOutput("t6_idle", 32'(oBusy), 32'h0);

    tick(2);
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
